// File: rtl/lockstep_commit_sched.sv
// Lockstep scheduler for two cpu_ooo copies: per-copy clock enables, stall of the early copy on
// commit deviation, public-info comparison of paired commits, and drain to a snapshotted ROB tail.
module lockstep_commit_sched #(
    parameter int ROB_SIZE_LOG  = 3,
    parameter int MEMD_SIZE_LOG = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c1_valid,
    input  logic                     c2_valid,
    input  logic                     c1_mem_valid,
    input  logic                     c2_mem_valid,
    input  logic                     c1_mem_rdwt,
    input  logic                     c2_mem_rdwt,
    input  logic [MEMD_SIZE_LOG-1:0] c1_mem_addr,
    input  logic [MEMD_SIZE_LOG-1:0] c2_mem_addr,
    input  logic                     c1_is_br,
    input  logic                     c2_is_br,
    input  logic                     c1_taken,
    input  logic                     c2_taken,
    input  logic                     c1_squash,
    input  logic                     c2_squash,
    input  logic [ROB_SIZE_LOG-1:0]  c1_rob_head,
    input  logic [ROB_SIZE_LOG-1:0]  c2_rob_head,
    input  logic [ROB_SIZE_LOG-1:0]  c1_rob_tail,
    input  logic [ROB_SIZE_LOG-1:0]  c2_rob_tail,
    output logic                     en_1,
    output logic                     en_2,
    output logic                     commit_deviation,
    output logic                     invalid_program,
    output logic                     finish_1,
    output logic                     finish_2,
    output logic                     done,
    output logic                     timeout
);

    typedef struct packed {
        logic                     mv;
        logic                     rd;
        logic [MEMD_SIZE_LOG-1:0] addr;
        logic                     br;
        logic                     tk;
    } commit_t;

    typedef enum logic [1:0] {S_LOCK, S_WAIT2, S_WAIT1, S_DONE} state_t;

    localparam logic [ROB_SIZE_LOG-1:0] ROB_ONE = 1;
    localparam logic [7:0]              TO_LIM  = 8'(TIMEOUT);

    state_t                  r_state, w_state_nxt;
    commit_t                 r_rec, w_rec_nxt, w_cm1, w_cm2;
    logic [7:0]              r_timer, w_timer_nxt, w_timer_inc;
    logic [ROB_SIZE_LOG-1:0] r_snap1, r_snap2, w_snap1, w_snap2;
    logic                    r_dev, r_inv, r_fin1, r_fin2, r_done, r_to;
    logic                    w_dev_nxt, w_inv_nxt, w_fin1_nxt, w_fin2_nxt, w_to_nxt, w_done_nxt;
    logic                    w_s1, w_s2;

    function automatic logic f_mismatch(input commit_t a, input commit_t b);
        return (a.mv & a.rd & b.mv & b.rd & (a.addr != b.addr)) |
               (a.br & b.br & (a.tk != b.tk));
    endfunction

    function automatic logic [7:0] f_sat_inc(input logic [7:0] t);
        return (t == 8'hFF) ? t : t + 8'd1;
    endfunction

    assign en_1 = (r_state == S_LOCK) || (r_state == S_WAIT1);
    assign en_2 = (r_state == S_LOCK) || (r_state == S_WAIT2);
    assign w_s1 = en_1 & c1_valid;
    assign w_s2 = en_2 & c2_valid;
    assign w_cm1 = {c1_mem_valid, c1_mem_rdwt, c1_mem_addr, c1_is_br, c1_taken};
    assign w_cm2 = {c2_mem_valid, c2_mem_rdwt, c2_mem_addr, c2_is_br, c2_taken};
    assign w_timer_inc = f_sat_inc(r_timer);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_rec_nxt   = r_rec;
        w_inv_nxt   = r_inv;
        w_dev_nxt   = r_dev;
        w_to_nxt    = r_to;
        case (r_state)
            S_LOCK: begin
                if (w_s1 && w_s2) begin
                    w_inv_nxt = r_inv | f_mismatch(w_cm1, w_cm2);
                end else if (w_s1) begin
                    w_rec_nxt   = w_cm1;
                    w_state_nxt = S_WAIT2;
                    w_dev_nxt   = 1'b1;
                end else if (w_s2) begin
                    w_rec_nxt   = w_cm2;
                    w_state_nxt = S_WAIT1;
                    w_dev_nxt   = 1'b1;
                end
            end
            S_WAIT2: begin
                // The awaited commit beats a coincident timeout.
                if (w_s2) begin
                    w_inv_nxt   = r_inv | f_mismatch(r_rec, w_cm2);
                    w_state_nxt = S_LOCK;
                    w_timer_nxt = 8'd0;
                end else begin
                    w_timer_nxt = w_timer_inc;
                    if (w_timer_inc == TO_LIM) begin
                        w_to_nxt    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT1: begin
                if (w_s1) begin
                    w_inv_nxt   = r_inv | f_mismatch(r_rec, w_cm1);
                    w_state_nxt = S_LOCK;
                    w_timer_nxt = 8'd0;
                end else begin
                    w_timer_nxt = w_timer_inc;
                    if (w_timer_inc == TO_LIM) begin
                        w_to_nxt    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: ;
        endcase

        // On the deviating cycle itself the live tails act as the snapshot.
        w_snap1    = r_dev ? r_snap1 : c1_rob_tail;
        w_snap2    = r_dev ? r_snap2 : c2_rob_tail;
        w_fin1_nxt = r_fin1 | (w_dev_nxt & w_s1 & (c1_squash | (c1_rob_head == w_snap1 - ROB_ONE)));
        w_fin2_nxt = r_fin2 | (w_dev_nxt & w_s2 & (c2_squash | (c2_rob_head == w_snap2 - ROB_ONE)));
        w_done_nxt = r_done | (w_fin1_nxt & w_fin2_nxt) | w_to_nxt;
        if (w_done_nxt) begin
            w_state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
            r_rec   <= '0;
            r_snap1 <= '0;
            r_snap2 <= '0;
            r_dev   <= 1'b0;
            r_inv   <= 1'b0;
            r_fin1  <= 1'b0;
            r_fin2  <= 1'b0;
            r_done  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_timer <= w_timer_nxt;
            r_rec   <= w_rec_nxt;
            if (!r_dev && w_dev_nxt) begin
                r_snap1 <= c1_rob_tail;
                r_snap2 <= c2_rob_tail;
            end
            r_dev   <= w_dev_nxt;
            r_inv   <= w_inv_nxt;
            r_fin1  <= w_fin1_nxt;
            r_fin2  <= w_fin2_nxt;
            r_done  <= w_done_nxt;
            r_to    <= w_to_nxt;
        end
    end

    assign commit_deviation = r_dev;
    assign invalid_program  = r_inv;
    assign finish_1         = r_fin1;
    assign finish_2         = r_fin2;
    assign done             = r_done;
    assign timeout          = r_to;

endmodule

// File: tb/tb_lockstep_commit_sched.sv
// Directed bench for lockstep_commit_sched; outputs packed as
// {en_1,en_2,commit_deviation,invalid_program,finish_1,finish_2,done,timeout}.
module tb_lockstep_commit_sched;

    logic       clk;
    logic       rst;
    logic       c1_valid, c2_valid, c1_mem_valid, c2_mem_valid, c1_mem_rdwt, c2_mem_rdwt;
    logic [1:0] c1_mem_addr, c2_mem_addr;
    logic       c1_is_br, c2_is_br, c1_taken, c2_taken, c1_squash, c2_squash;
    logic [2:0] c1_rob_head, c2_rob_head, c1_rob_tail, c2_rob_tail;
    logic       en_1, en_2, commit_deviation, invalid_program, finish_1, finish_2, done, timeout;
    logic [7:0] outs;
    int         errors = 0;
    int         checks = 0;

    assign outs = {en_1, en_2, commit_deviation, invalid_program, finish_1, finish_2, done, timeout};

    lockstep_commit_sched dut (
        .clk(clk), .rst(rst),
        .c1_valid(c1_valid), .c2_valid(c2_valid),
        .c1_mem_valid(c1_mem_valid), .c2_mem_valid(c2_mem_valid),
        .c1_mem_rdwt(c1_mem_rdwt), .c2_mem_rdwt(c2_mem_rdwt),
        .c1_mem_addr(c1_mem_addr), .c2_mem_addr(c2_mem_addr),
        .c1_is_br(c1_is_br), .c2_is_br(c2_is_br),
        .c1_taken(c1_taken), .c2_taken(c2_taken),
        .c1_squash(c1_squash), .c2_squash(c2_squash),
        .c1_rob_head(c1_rob_head), .c2_rob_head(c2_rob_head),
        .c1_rob_tail(c1_rob_tail), .c2_rob_tail(c2_rob_tail),
        .en_1(en_1), .en_2(en_2),
        .commit_deviation(commit_deviation), .invalid_program(invalid_program),
        .finish_1(finish_1), .finish_2(finish_2),
        .done(done), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c1(input logic v, input logic mv, input logic rd, input logic [1:0] a,
                          input logic br, input logic tk, input logic sq,
                          input logic [2:0] hd, input logic [2:0] tl);
        c1_valid = v; c1_mem_valid = mv; c1_mem_rdwt = rd; c1_mem_addr = a;
        c1_is_br = br; c1_taken = tk; c1_squash = sq; c1_rob_head = hd; c1_rob_tail = tl;
    endtask

    task automatic set_c2(input logic v, input logic mv, input logic rd, input logic [1:0] a,
                          input logic br, input logic tk, input logic sq,
                          input logic [2:0] hd, input logic [2:0] tl);
        c2_valid = v; c2_mem_valid = mv; c2_mem_rdwt = rd; c2_mem_addr = a;
        c2_is_br = br; c2_taken = tk; c2_squash = sq; c2_rob_head = hd; c2_rob_tail = tl;
    endtask

    task automatic idle();
        set_c1(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        set_c2(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
    endtask

    task automatic do_reset();
        idle();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        checks++; if (outs !== 8'b1100_0000) begin errors++; $display("FAIL reset_async got=%b exp=%b", outs, 8'b1100_0000); end
        tick();
        checks++; if (outs !== 8'b1100_0000) begin errors++; $display("FAIL reset_held got=%b exp=%b", outs, 8'b1100_0000); end
        #2 rst = 1'b1;
        tick();
        checks++; if (outs !== 8'b1100_0000) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, 8'b1100_0000); end
    endtask

    task automatic test_lockstep();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_c1(1, 1, 1, 2'd2, 0, 0, 0, 3'd0, 3'd0);
            set_c2(1, 1, 1, 2'd2, 0, 0, 0, 3'd0, 3'd0);
            tick();
            checks++; if (outs !== 8'b1100_0000) begin errors++; $display("FAIL lockstep_c%0d got=%b exp=%b", i, outs, 8'b1100_0000); end
        end
    endtask

    task automatic test_dev_match();
        do_reset();
        set_c1(1, 1, 1, 2'd1, 0, 0, 0, 3'd0, 3'd5);
        set_c2(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd3);
        tick();
        checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL dev_enter got=%b exp=%b", outs, 8'b0110_0000); end
        // copy1 is held: head 4 would drain it if its inputs were not ignored
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd4, 3'd5);
        tick();
        checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL dev_hold got=%b exp=%b", outs, 8'b0110_0000); end
        set_c2(1, 1, 1, 2'd1, 0, 0, 0, 3'd0, 3'd3);
        tick();
        checks++; if (outs !== 8'b1110_0000) begin errors++; $display("FAIL dev_pair_ok got=%b exp=%b", outs, 8'b1110_0000); end
        set_c1(1, 1, 1, 2'd1, 0, 0, 0, 3'd0, 3'd5);
        set_c2(1, 1, 1, 2'd2, 0, 0, 0, 3'd0, 3'd3);
        tick();
        checks++; if (outs !== 8'b1111_0000) begin errors++; $display("FAIL lock_addr_diff got=%b exp=%b", outs, 8'b1111_0000); end
    endtask

    task automatic test_store_no_flag();
        do_reset();
        set_c1(1, 1, 1, 2'd1, 0, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL store_enter got=%b exp=%b", outs, 8'b0110_0000); end
        idle();
        set_c2(1, 1, 0, 2'd3, 0, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b1110_0000) begin errors++; $display("FAIL store_pair got=%b exp=%b", outs, 8'b1110_0000); end
    endtask

    task automatic test_branch();
        do_reset();
        set_c1(1, 0, 0, 2'd0, 1, 1, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL br_enter got=%b exp=%b", outs, 8'b0110_0000); end
        idle();
        tick();
        checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL br_wait got=%b exp=%b", outs, 8'b0110_0000); end
        set_c2(1, 0, 0, 2'd0, 1, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b1111_0000) begin errors++; $display("FAIL br_mismatch got=%b exp=%b", outs, 8'b1111_0000); end
        for (int i = 0; i < 2; i++) begin
            set_c1(1, 0, 0, 2'd0, 1, 1, 0, 3'd0, 3'd0);
            set_c2(1, 0, 0, 2'd0, 1, 1, 0, 3'd0, 3'd0);
            tick();
            checks++; if (outs !== 8'b1111_0000) begin errors++; $display("FAIL br_sticky%0d got=%b exp=%b", i, outs, 8'b1111_0000); end
        end
    endtask

    task automatic test_drain();
        do_reset();
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        set_c2(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd4);
        tick();
        checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL drain_enter got=%b exp=%b", outs, 8'b0110_0000); end
        set_c1(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        set_c2(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd4);
        tick();
        checks++; if (outs !== 8'b1110_0000) begin errors++; $display("FAIL drain_relock got=%b exp=%b", outs, 8'b1110_0000); end
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd7, 3'd6);
        set_c2(1, 0, 0, 2'd0, 0, 0, 0, 3'd2, 3'd6);
        tick();
        checks++; if (outs !== 8'b1110_1000) begin errors++; $display("FAIL drain_fin1 got=%b exp=%b", outs, 8'b1110_1000); end
        set_c1(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd6);
        set_c2(1, 0, 0, 2'd0, 0, 0, 0, 3'd3, 3'd6);
        tick();
        checks++; if (outs !== 8'b0010_1110) begin errors++; $display("FAIL drain_fin2 got=%b exp=%b", outs, 8'b0010_1110); end
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        set_c2(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b0010_1110) begin errors++; $display("FAIL drain_absorb got=%b exp=%b", outs, 8'b0010_1110); end
    endtask

    task automatic test_squash();
        do_reset();
        set_c2(1, 0, 0, 2'd0, 0, 0, 1, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b1010_0100) begin errors++; $display("FAIL squash_fin2 got=%b exp=%b", outs, 8'b1010_0100); end
        set_c2(0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd7, 3'd0);
        tick();
        checks++; if (outs !== 8'b0010_1110) begin errors++; $display("FAIL wait_done_fin1 got=%b exp=%b", outs, 8'b0010_1110); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        tick();
        idle();
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL to_wait%0d got=%b exp=%b", i, outs, 8'b0110_0000); end
        end
        tick();
        checks++; if (outs !== 8'b0110_0011 && outs !== 8'b0010_0011) begin errors++; $display("FAIL to_fire got=%b exp=%b", outs, 8'b0010_0011); end
        checks++; if ({en_1, en_2} !== 2'b00) begin errors++; $display("FAIL to_en got=%b exp=%b", {en_1, en_2}, 2'b00); end
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        set_c2(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b0010_0011) begin errors++; $display("FAIL to_absorb got=%b exp=%b", outs, 8'b0010_0011); end
    endtask

    task automatic test_timeout_commit_wins();
        do_reset();
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        tick();
        idle();
        for (int i = 1; i <= 15; i++) tick();
        set_c2(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b1110_0000) begin errors++; $display("FAIL tw_commit got=%b exp=%b", outs, 8'b1110_0000); end
        idle();
        set_c1(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        tick();
        idle();
        for (int i = 1; i <= 15; i++) tick();
        checks++; if (outs !== 8'b0110_0000) begin errors++; $display("FAIL tw_cleared got=%b exp=%b", outs, 8'b0110_0000); end
        tick();
        checks++; if (outs !== 8'b0010_0011) begin errors++; $display("FAIL tw_refire got=%b exp=%b", outs, 8'b0010_0011); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_c2(1, 0, 0, 2'd0, 0, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b1010_0000) begin errors++; $display("FAIL ar_wait1 got=%b exp=%b", outs, 8'b1010_0000); end
        idle();
        #2 rst = 1'b0;
        #1;
        checks++; if (outs !== 8'b1100_0000) begin errors++; $display("FAIL ar_clear got=%b exp=%b", outs, 8'b1100_0000); end
        #2 rst = 1'b1;
        set_c1(1, 1, 1, 2'd2, 0, 0, 0, 3'd0, 3'd0);
        set_c2(1, 1, 1, 2'd2, 0, 0, 0, 3'd0, 3'd0);
        tick();
        checks++; if (outs !== 8'b1100_0000) begin errors++; $display("FAIL ar_resume got=%b exp=%b", outs, 8'b1100_0000); end
    endtask

    initial begin
        test_reset();
        test_lockstep();
        test_dev_match();
        test_store_no_flag();
        test_branch();
        test_drain();
        test_squash();
        test_timeout();
        test_timeout_commit_wins();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
